instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
- Sequential program loader that turns field-level instruction descriptors into 32-bit machine words of the single-cycle datapath's subset (DP ADD/SUB/AND/ORR/MOV/CMP, LDR/STR immediate offset, B/BL).
- Writes the words into instruction memory at consecutive word addresses.
- Inverse of the control decoder: the decoder must recover exactly the control intent the descriptor expressed from every word this block emits.
- Sits between the host/debug load path and the imem write port; used at boot and by testbenches to load programs.

Parameters:
AW, 32, width of wr_addr (byte address).
BASE_ADDR, 0, first byte address written after start.
MAX_WORDS, 256, capacity; load ends when this many words have been emitted.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; begins a load session (ignored unless IDLE)
in_valid  in  1  descriptor valid
in_ready  out  1  descriptor accepted when in_valid && in_ready
in_cls  in  2  00 DP, 01 MEM, 10 BRANCH, 11 illegal
in_cond  in  4  condition field
in_funct  in  4  DP funct code
in_i  in  1  DP immediate select
in_s  in  1  DP set-flags
in_l  in  1  MEM: 1 LDR / 0 STR; BRANCH: 1 BL / 0 B
in_rn  in  4  base/first operand register
in_rd  in  4  destination/source register
in_src2  in  12  DP Src2 or MEM imm12
in_imm24  in  24  branch offset
in_last  in  1  final descriptor of the session
wr_valid  out  1  imem write request
wr_ready  in  1  imem accepts write
wr_addr  out  AW  byte address of word
wr_data  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at session end
err  out  1  sticky illegal-descriptor flag
word_count  out  9  words emitted this session

Behaviour:
- Reset (async, rst_n=0): state IDLE, in_ready=0, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, err=0, word_count=0. Reset mid-session aborts; a pending write is dropped immediately.
- States:
  - IDLE: on start -> LOAD; addr<=BASE_ADDR, count<=0, err<=0.
  - LOAD: accept descriptors. After the accepted beat has in_last=1, or count reaches MAX_WORDS -> DRAIN.
  - DRAIN: wait until wr_valid=0, then pulse done for one cycle -> IDLE.
- in_ready = (state==LOAD) && (!wr_valid || wr_ready) && (count < MAX_WORDS).
- Single output register; latency 1 cycle from acceptance to wr_valid. Throughput 1 word/cycle when wr_ready stays high.
- wr_valid/wr_addr/wr_data hold stable while wr_valid && !wr_ready.
- On write handshake: wr_addr += 4 (wraps modulo 2^AW), word_count += 1.
- Encoding, all classes: [31:28]=cond, [27:26]=cls.
  - DP: [25]=I, [24:21]=funct, [20]=S, [19:16]=Rn, [15:12]=Rd, [11:0]=src2.
    - CMP (1010): S forced 1, Rd forced 0.
    - MOV (1101): Rn forced 0.
    - Other funct codes are illegal.
  - MEM: [25]=0, [24:21]=1100 (P=1,U=1,B=0,W=0), [20]=L, Rn/Rd as DP, [11:0]=imm12.
  - BRANCH: [25]=1, [24]=L, [23:0]=imm24.
- Illegal descriptor (cls=11 or illegal DP funct): consumed; err<=1; no word emitted; address not advanced. in_last on an illegal beat still ends the session.
- start during LOAD/DRAIN: ignored. in_valid outside LOAD: ignored, in_ready=0.
- Same-cycle acceptance and output handshake: the new word overwrites the register. Address and count advance once for the departing word.

Decomposition:
- Package arm_isa_pkg holds:
  - class codes OP_DP/OP_MEM/OP_B
  - FUNCT_* codes
  - COND_AL=4'hE
  - MEM_PUBW=4'b1100
  - loader state enum
- Sub-module instr_word_encoder: purely combinational fields->{word, illegal}; reusable by the decoder's testbench.

Test Plan:
- start; ADD cond=E,I=1,S=0,Rn=2,Rd=1,src2=005, last -> one write addr 0x0 data E2821005, then done pulse; word_count=1.
- Burst of CMP Rn=3,Rd=7,S=0,I=1,src2=0 / MOV I=1,Rn=9,Rd=0,src2=1 / LDR Rn=5,Rd=4,imm=8 / STR same / B imm24=2 / BL imm24=2 -> E3530000, E3A00001, E5954008, E5854008, EA000002, EB000002 at addrs 0,4,8,C,10,14.
- wr_ready held 0 for 5 cycles mid-burst -> in_ready=0, wr_* stable; no loss or duplication after release.
- cls=11 then funct=0111 then valid ADD -> err=1; only the ADD word is written, at addr 0; err clears on next start.
- MAX_WORDS=4 with 6 descriptors, no last -> exactly 4 writes, in_ready drops, done pulses; start pulsed during LOAD has no effect.
- rst_n asserted while wr_valid=1 mid-session -> all outputs reset values immediately; new start writes at BASE_ADDR.

Source files
------------

// File: rtl/arm_isa_pkg.sv
// arm_isa_pkg: instruction-class, funct and condition codes plus loader state enum
package arm_isa_pkg;
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_B   = 2'b10;
  localparam logic [3:0] FUNCT_AND = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b0010;
  localparam logic [3:0] FUNCT_ADD = 4'b0100;
  localparam logic [3:0] FUNCT_CMP = 4'b1010;
  localparam logic [3:0] FUNCT_ORR = 4'b1100;
  localparam logic [3:0] FUNCT_MOV = 4'b1101;
  localparam logic [3:0] COND_AL   = 4'hE;
  localparam logic [3:0] MEM_PUBW  = 4'b1100;
  typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_DRAIN} loader_state_e;
endpackage

// File: rtl/instr_encode_loader_encoder.sv
// instr_word_encoder: combinational descriptor fields -> 32-bit machine word plus illegal flag
module instr_word_encoder
  import arm_isa_pkg::*;
(
  input  logic [1:0]  cls_i,
  input  logic [3:0]  cond_i,
  input  logic [3:0]  funct_i,
  input  logic        i_i,
  input  logic        s_i,
  input  logic        l_i,
  input  logic [3:0]  rn_i,
  input  logic [3:0]  rd_i,
  input  logic [11:0] src2_i,
  input  logic [23:0] imm24_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);
  logic is_cmp, is_mov, dp_ok;
  assign is_cmp = funct_i == FUNCT_CMP;
  assign is_mov = funct_i == FUNCT_MOV;
  assign dp_ok = funct_i inside {FUNCT_AND, FUNCT_SUB, FUNCT_ADD, FUNCT_ORR, FUNCT_CMP, FUNCT_MOV};
  assign illegal_o = (cls_i == 2'b11) || (cls_i == OP_DP && !dp_ok);
  assign word_o = cls_i == OP_DP  ? {cond_i, OP_DP, i_i, funct_i, s_i | is_cmp, is_mov ? 4'h0 : rn_i,
                                     is_cmp ? 4'h0 : rd_i, src2_i} :
                  cls_i == OP_MEM ? {cond_i, OP_MEM, 1'b0, MEM_PUBW, l_i, rn_i, rd_i, src2_i} :
                  cls_i == OP_B   ? {cond_i, OP_B, 1'b1, l_i, imm24_i} : 32'h0;
endmodule

// File: rtl/instr_encode_loader.sv
// instr_encode_loader: accepts instruction descriptors, encodes them and streams words to imem at consecutive addresses
module instr_encode_loader
  import arm_isa_pkg::*;
#(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_cls,
  input  logic [3:0]    in_cond,
  input  logic [3:0]    in_funct,
  input  logic          in_i,
  input  logic          in_s,
  input  logic          in_l,
  input  logic [3:0]    in_rn,
  input  logic [3:0]    in_rd,
  input  logic [11:0]   in_src2,
  input  logic [23:0]   in_imm24,
  input  logic          in_last,
  output logic          wr_valid,
  input  logic          wr_ready,
  output logic [AW-1:0] wr_addr,
  output logic [31:0]   wr_data,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [8:0]    word_count
);
  loader_state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d, enc_word;
  logic          wv_q, wv_d, err_q, err_d, enc_ill, acc, hs, go, emit;
  logic [8:0]    cnt_q, cnt_d, iss_q, iss_d;
  instr_word_encoder u_enc (
    .cls_i(in_cls), .cond_i(in_cond), .funct_i(in_funct), .i_i(in_i), .s_i(in_s), .l_i(in_l),
    .rn_i(in_rn), .rd_i(in_rd), .src2_i(in_src2), .imm24_i(in_imm24),
    .word_o(enc_word), .illegal_o(enc_ill)
  );
  // iss_q counts words accepted into the output register; it bounds capacity so a word
  // still waiting for wr_ready cannot let one extra descriptor slip in
  assign in_ready = state_q == LD_LOAD && (!wv_q || wr_ready) && iss_q < 9'(MAX_WORDS);
  assign acc = in_valid & in_ready;
  assign emit = acc & !enc_ill;
  assign hs = wv_q & wr_ready;
  assign go = state_q == LD_IDLE && start;
  always_comb begin
    addr_d  = go ? BASE_ADDR : hs ? addr_q + AW'(4) : addr_q;
    cnt_d   = go ? 9'd0 : hs ? cnt_q + 9'd1 : cnt_q;
    iss_d   = go ? 9'd0 : emit ? iss_q + 9'd1 : iss_q;
    err_d   = go ? 1'b0 : (acc && enc_ill) ? 1'b1 : err_q;
    wv_d    = emit ? 1'b1 : hs ? 1'b0 : wv_q;
    data_d  = emit ? enc_word : data_q;
    state_d = go ? LD_LOAD :
              (acc && (in_last || iss_d == 9'(MAX_WORDS))) ? LD_DRAIN :
              (state_q == LD_DRAIN && !wv_q) ? LD_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LD_IDLE;
      addr_q  <= BASE_ADDR;
      data_q  <= '0;
      wv_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      iss_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wv_q    <= wv_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
    end
  end
  assign wr_valid   = wv_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign busy       = state_q != LD_IDLE;
  assign done       = state_q == LD_DRAIN && !wv_q;
  assign err        = err_q;
  assign word_count = cnt_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// tb_instr_encode_loader: directed stimulus with a behavioural loader model and literal spot checks
module tb_instr_encode_loader;
  localparam int MW = 8;
  logic clk = 0, rst_n = 1, start = 0, in_valid = 0, in_i = 0, in_s = 0, in_l = 0, in_last = 0, wr_ready = 1;
  logic [1:0] in_cls = 0;
  logic [3:0] in_cond = 0, in_funct = 0, in_rn = 0, in_rd = 0;
  logic [11:0] in_src2 = 0;
  logic [23:0] in_imm24 = 0;
  logic in_ready, wr_valid, busy, done, err;
  logic [31:0] wr_addr, wr_data;
  logic [8:0] word_count;
  int checks = 0, errors = 0;
  logic [63:0] expq[$], wlog[$];
  int cnt_m = 0, iss_m = 0;
  logic err_m = 0, idle_m = 1, closing_m = 0, stall_prev = 0, exp_done;
  logic [31:0] held_a, held_d;
  logic [63:0] e;
  logic [32:0] r;
  logic [31:0] lit_b [6] = '{32'hE3530000, 32'hE3A00001, 32'hE5954008, 32'hE5854008, 32'hEA000002, 32'hEB000002};

  instr_encode_loader #(.AW(32), .BASE_ADDR(32'h0), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_cond(in_cond), .in_funct(in_funct), .in_i(in_i), .in_s(in_s), .in_l(in_l),
    .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_imm24(in_imm24), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [32:0] model_word(input logic [1:0] c, input logic [3:0] cond, f,
      input logic i, s, l, input logic [3:0] rn, rd, input logic [11:0] s2, input logic [23:0] imm);
    logic [31:0] w;
    logic bad, se;
    logic [3:0] rne, rde;
    w = (32'(cond) << 28) | (32'(c) << 26);
    bad = 0;
    if (c == 2'd0) begin
      bad = !(f inside {4'h0, 4'h2, 4'h4, 4'hC, 4'hD, 4'hA});
      se = (f == 4'hA) ? 1'b1 : s;
      rde = (f == 4'hA) ? 4'h0 : rd;
      rne = (f == 4'hD) ? 4'h0 : rn;
      w = w | (32'(i) << 25) | (32'(f) << 21) | (32'(se) << 20) | (32'(rne) << 16) | (32'(rde) << 12) | 32'(s2);
    end else if (c == 2'd1)
      w = w | (32'hC << 21) | (32'(l) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(s2);
    else if (c == 2'd2)
      w = w | (32'h1 << 25) | (32'(l) << 24) | 32'(imm);
    else
      bad = 1;
    return {bad, w};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      cnt_m = 0; iss_m = 0; err_m = 0; idle_m = 1; closing_m = 0; stall_prev = 0;
    end else begin
      exp_done = closing_m && expq.size() == 0;
      chk("word_count", 32'(word_count), 32'(cnt_m));
      chk("err", 32'(err), 32'(err_m));
      chk("busy", 32'(busy), 32'(!idle_m));
      chk("done", 32'(done), 32'(exp_done));
      chk("in_ready", 32'(in_ready), 32'(!idle_m && !closing_m && (!wr_valid || wr_ready) && iss_m < MW));
      if (stall_prev) begin
        chk("stall_valid", 32'(wr_valid), 32'd1);
        chk("stall_addr", wr_addr, held_a);
        chk("stall_data", wr_data, held_d);
      end
      stall_prev = wr_valid && !wr_ready;
      held_a = wr_addr;
      held_d = wr_data;
      if (wr_valid && wr_ready) begin
        wlog.push_back({wr_addr, wr_data});
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
        end else begin
          e = expq.pop_front();
          chk("wr_addr", wr_addr, e[63:32]);
          chk("wr_data", wr_data, e[31:0]);
        end
        cnt_m++;
      end
      if (start && idle_m) begin
        idle_m = 0; cnt_m = 0; iss_m = 0; err_m = 0;
      end
      if (in_valid && in_ready) begin
        r = model_word(in_cls, in_cond, in_funct, in_i, in_s, in_l, in_rn, in_rd, in_src2, in_imm24);
        if (r[32]) err_m = 1;
        else begin
          expq.push_back({32'(4 * iss_m), r[31:0]});
          iss_m++;
        end
        if (in_last || iss_m == MW) closing_m = 1;
      end
      if (exp_done) begin
        idle_m = 1; closing_m = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] cond, f, input logic i, s, l,
      input logic [3:0] rn, rd, input logic [11:0] s2, input logic [23:0] imm, input logic last);
    in_valid = 1; in_cls = c; in_cond = cond; in_funct = f; in_i = i; in_s = s; in_l = l;
    in_rn = rn; in_rd = rd; in_src2 = s2; in_imm24 = imm; in_last = last;
  endtask

  task automatic wait_acc();
    int k;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (k == 30) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 30 cycles");
    end
    @(posedge clk); #1 in_valid = 0; in_last = 0;
  endtask

  task automatic send(input logic [1:0] c, input logic [3:0] cond, f, input logic i, s, l,
      input logic [3:0] rn, rd, input logic [11:0] s2, input logic [23:0] imm, input logic last);
    drive(c, cond, f, i, s, l, rn, rd, s2, imm, last);
    wait_acc();
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (k == 50) begin
      errors++;
      $display("FAIL done_timeout: got done 0 expected 1 within 50 cycles");
    end
  endtask

  initial begin
    #2 rst_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_count", 32'(word_count), 0);
    @(posedge clk); #1 rst_n = 1;
    wlog.delete();
    pulse_start();
    send(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0, 1);
    wait_done();
    chk("t1_count", 32'(word_count), 1);
    chk("t1_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("t1_addr", wlog[0][63:32], 32'h0);
      chk("t1_data", wlog[0][31:0], 32'hE2821005);
    end
    wlog.delete();
    pulse_start();
    send(2'd0, 4'hE, 4'hA, 1, 0, 0, 4'd3, 4'd7, 12'h000, 0, 0);
    send(2'd0, 4'hE, 4'hD, 1, 0, 0, 4'd9, 4'd0, 12'h001, 0, 0);
    send(2'd1, 4'hE, 4'h0, 0, 0, 1, 4'd5, 4'd4, 12'h008, 0, 0);
    send(2'd1, 4'hE, 4'h0, 0, 0, 0, 4'd5, 4'd4, 12'h008, 0, 0);
    send(2'd2, 4'hE, 4'h0, 0, 0, 0, 4'd0, 4'd0, 12'h000, 24'd2, 0);
    send(2'd2, 4'hE, 4'h0, 0, 0, 1, 4'd0, 4'd0, 12'h000, 24'd2, 1);
    wait_done();
    chk("t2_nwrites", wlog.size(), 6);
    if (wlog.size() == 6)
      for (int k = 0; k < 6; k++) begin
        chk("t2_addr", wlog[k][63:32], 32'(4 * k));
        chk("t2_data", wlog[k][31:0], lit_b[k]);
      end
    wlog.delete();
    pulse_start();
    send(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0, 0);
    wr_ready = 0;
    drive(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd2, 12'h005, 0, 0);
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_word", wr_data, 32'hE2821005);
    end
    @(posedge clk); #1 wr_ready = 1;
    wait_acc();
    send(2'd0, 4'hE, 4'h2, 1, 0, 0, 4'd2, 4'd3, 12'h005, 0, 0);
    send(2'd0, 4'hE, 4'hC, 1, 0, 0, 4'd2, 4'd4, 12'h005, 0, 1);
    wait_done();
    chk("t3_count", 32'(word_count), 4);
    chk("t3_nwrites", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t3_sub", wlog[2][31:0], 32'hE2423005);
      chk("t3_orr", wlog[3][31:0], 32'hE3824005);
    end
    wlog.delete();
    pulse_start();
    send(2'd3, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0, 0);
    send(2'd0, 4'hE, 4'h7, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0, 0);
    send(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0, 1);
    wait_done();
    chk("t4_err", 32'(err), 1);
    chk("t4_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) chk("t4_word", wlog[0][31:0], 32'hE2821005);
    if (wlog.size() == 1) chk("t4_addr", wlog[0][63:32], 32'h0);
    wlog.delete();
    pulse_start();
    chk("t5_err_clear", 32'(err), 0);
    for (int k = 0; k < MW; k++) begin
      if (k == 3) pulse_start();
      send(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'(k), 12'h005, 0, 0);
    end
    drive(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd9, 12'h005, 0, 0);
    @(negedge clk);
    chk("t5_full_ready", 32'(in_ready), 0);
    @(posedge clk); #1 in_valid = 0;
    wait_done();
    chk("t5_count", 32'(word_count), MW);
    chk("t5_nwrites", wlog.size(), MW);
    if (wlog.size() == MW) chk("t5_last_addr", wlog[MW-1][63:32], 32'(4 * (MW - 1)));
    wlog.delete();
    pulse_start();
    wr_ready = 0;
    send(2'd0, 4'hE, 4'h4, 1, 0, 0, 4'd2, 4'd1, 12'h005, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("arst_wr_valid", 32'(wr_valid), 0);
    chk("arst_wr_addr", wr_addr, 0);
    chk("arst_wr_data", wr_data, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(word_count), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 rst_n = 1; wr_ready = 1;
    wlog.delete();
    pulse_start();
    send(2'd0, 4'hE, 4'h0, 0, 1, 0, 4'd6, 4'd5, 12'h0F3, 0, 1);
    wait_done();
    chk("t6_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("t6_addr", wlog[0][63:32], 32'h0);
      chk("t6_data", wlog[0][31:0], 32'hE01650F3);
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
